receptor_digitos: RTL and testbench

- Receiving end of the keypad-encoder interface. Consumes the encoded BCD digit bus plus its active-low load strobe.
- Assembles typed digits into an m:ss entry buffer, right-shifted microwave-style, and drives a live preview to the seven-segment decoder.
- On a start request, normalises the entry and hands it to the timer through a req/ack load handshake.
- Sits between the keypad encoder and the timer/decoder in the oven top level.

---
 rtl/microondas_pkg.sv | 17 +
 rtl/norm_mss.sv | 30 +++
 rtl/receptor_digitos.sv | 144 ++++++++++++++
 tb/tb_receptor_digitos.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared types and BCD limits for the microwave oven digit path.
package microondas_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StNorm,
    StLoad
  } state_t;

  localparam digit_t MAX_DEZ = 4'd5;
  localparam digit_t MAX_MIN = 4'd9;
  localparam digit_t DIG_MAX = 4'd9;

endpackage

// File: rtl/norm_mss.sv
// Combinational m:ss normalisation: folds tens-of-seconds above 5 into minutes,
// saturating at 9:59.
module norm_mss
  import microondas_pkg::*;
(
  input  logic [3:0] minutos_i,
  input  logic [3:0] dezenas_i,
  input  logic [3:0] unidades_i,
  output logic [3:0] minutos_o,
  output logic [3:0] dezenas_o,
  output logic [3:0] unidades_o
);

  always_comb begin
    minutos_o  = minutos_i;
    dezenas_o  = dezenas_i;
    unidades_o = unidades_i;
    if (dezenas_i > MAX_DEZ) begin
      if (minutos_i < MAX_MIN) begin
        minutos_o = minutos_i + 4'd1;
        dezenas_o = dezenas_i - 4'd6;
      end else begin
        minutos_o  = MAX_MIN;
        dezenas_o  = MAX_DEZ;
        unidades_o = DIG_MAX;
      end
    end
  end

endmodule

// File: rtl/receptor_digitos.sv
// Keypad digit receiver: builds a right-shifted m:ss entry, previews it, and hands the
// normalised value to the timer over a req/ack load handshake.
module receptor_digitos
  import microondas_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TW      = 10
) (
  input  logic       clk100Hz,
  input  logic       clrn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       enablen,
  input  logic       start_req,
  input  logic       cancel,
  input  logic       load_ack,
  output logic [3:0] prev_unidades,
  output logic [3:0] prev_dezenas,
  output logic [3:0] prev_minutos,
  output logic [3:0] tmp_unidades,
  output logic [3:0] tmp_dezenas,
  output logic [3:0] tmp_minutos,
  output logic       load_req,
  output logic [1:0] n_digitos,
  output logic       erro
);

  state_t        state_q, state_d;
  digit_t        min_q, min_d, dez_q, dez_d, uni_q, uni_d;
  logic [1:0]    n_q, n_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          erro_q, erro_d;
  logic          loadn_s1_q, loadn_s2_q, loadn_prev_q;
  logic          key_ev;

  assign key_ev = loadn_prev_q & ~loadn_s2_q;

  always_ff @(posedge clk100Hz or negedge clrn) begin
    if (!clrn) begin
      state_q      <= StIdle;
      min_q        <= '0;
      dez_q        <= '0;
      uni_q        <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      erro_q       <= 1'b0;
      loadn_s1_q   <= 1'b1;
      loadn_s2_q   <= 1'b1;
      loadn_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      dez_q        <= dez_d;
      uni_q        <= uni_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      erro_q       <= erro_d;
      loadn_s1_q   <= loadn;
      loadn_s2_q   <= loadn_s1_q;
      loadn_prev_q <= loadn_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    dez_d   = dez_q;
    uni_d   = uni_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    erro_d  = 1'b0;
    case (state_q)
      StIdle, StEntry: begin
        // Timeout is the lowest-priority action; cancel/start/key override it below.
        if (state_q == StEntry) begin
          if (cnt_q == TW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            {min_d, dez_d, uni_d} = '0;
            n_d   = '0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        if (cancel) begin
          state_d = StIdle;
          {min_d, dez_d, uni_d} = '0;
          n_d   = '0;
          cnt_d = '0;
        end else if (start_req && state_q == StEntry && n_q != 2'd0) begin
          state_d = StNorm;
          cnt_d   = '0;
        end else if (key_ev && !enablen) begin
          if (D > DIG_MAX) begin
            erro_d = 1'b1;
          end else begin
            state_d = StEntry;
            min_d   = dez_q;
            dez_d   = uni_q;
            uni_d   = D;
            n_d     = (n_q == 2'd3) ? n_q : n_q + 2'd1;
            cnt_d   = '0;
          end
        end
      end
      StNorm: state_d = StLoad;
      StLoad: begin
        if (load_ack) begin
          state_d = StIdle;
          {min_d, dez_d, uni_d} = '0;
          n_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Buffer is frozen in NORM/LOAD, so the combinational result stays stable under load_req.
  norm_mss u_norm (
    .minutos_i  (min_q),
    .dezenas_i  (dez_q),
    .unidades_i (uni_q),
    .minutos_o  (tmp_minutos),
    .dezenas_o  (tmp_dezenas),
    .unidades_o (tmp_unidades)
  );

  always_comb begin
    if (state_q == StNorm || state_q == StLoad) begin
      prev_minutos  = tmp_minutos;
      prev_dezenas  = tmp_dezenas;
      prev_unidades = tmp_unidades;
    end else begin
      prev_minutos  = min_q;
      prev_dezenas  = dez_q;
      prev_unidades = uni_q;
    end
  end

  assign load_req  = (state_q == StLoad);
  assign n_digitos = n_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_receptor_digitos.sv
// Directed bench for receptor_digitos: entry, normalisation, handshake, errors, timeout, reset.
module tb_receptor_digitos;

  logic       clk100Hz = 1'b0;
  logic       clrn;
  logic [3:0] D;
  logic       loadn, enablen, start_req, cancel, load_ack;
  logic [3:0] prev_unidades, prev_dezenas, prev_minutos;
  logic [3:0] tmp_unidades, tmp_dezenas, tmp_minutos;
  logic       load_req, erro;
  logic [1:0] n_digitos;

  int checks   = 0;
  int failures = 0;

  receptor_digitos dut (
    .clk100Hz      (clk100Hz),
    .clrn          (clrn),
    .D             (D),
    .loadn         (loadn),
    .enablen       (enablen),
    .start_req     (start_req),
    .cancel        (cancel),
    .load_ack      (load_ack),
    .prev_unidades (prev_unidades),
    .prev_dezenas  (prev_dezenas),
    .prev_minutos  (prev_minutos),
    .tmp_unidades  (tmp_unidades),
    .tmp_dezenas   (tmp_dezenas),
    .tmp_minutos   (tmp_minutos),
    .load_req      (load_req),
    .n_digitos     (n_digitos),
    .erro          (erro)
  );

  always #5 clk100Hz = ~clk100Hz;

  function automatic logic [11:0] pv();
    return {prev_minutos, prev_dezenas, prev_unidades};
  endfunction

  function automatic logic [11:0] tv();
    return {tmp_minutos, tmp_dezenas, tmp_unidades};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100Hz);
    #1;
  endtask

  // Key is accepted on the third edge after loadn falls (2-flop sync + edge detect).
  task automatic press(input logic [3:0] d);
    D     = d;
    loadn = 1'b0;
    repeat (3) tick();
    loadn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic start_and_ack(input string tag, input logic [11:0] exp);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    chk({tag, "_norm_req"}, 12'(load_req), 12'h0);
    tick();
    chk({tag, "_load_req"}, 12'(load_req), 12'h1);
    chk({tag, "_tmp"}, tv(), exp);
    chk({tag, "_prev"}, pv(), exp);
    tick();
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    chk({tag, "_ack_req"}, 12'(load_req), 12'h0);
    chk({tag, "_ack_prev"}, pv(), 12'h000);
    chk({tag, "_ack_n"}, 12'(n_digitos), 12'h0);
  endtask

  initial begin
    clrn = 1'b0; D = 4'd0; loadn = 1'b1; enablen = 1'b0;
    start_req = 1'b0; cancel = 1'b0; load_ack = 1'b0;
    tick();
    chk("rst_prev", pv(), 12'h000);
    chk("rst_tmp", tv(), 12'h000);
    chk("rst_req", 12'(load_req), 12'h0);
    chk("rst_n", 12'(n_digitos), 12'h0);
    chk("rst_erro", 12'(erro), 12'h0);
    clrn = 1'b1;
    tick();

    press(4'd1); press(4'd3); press(4'd0);
    chk("e130_prev", pv(), 12'h130);
    chk("e130_n", 12'(n_digitos), 12'h3);
    start_and_ack("e130", 12'h130);

    press(4'd0); press(4'd7); press(4'd5);
    chk("e075_prev", pv(), 12'h075);
    start_and_ack("e075", 12'h115);

    press(4'd9); press(4'd8); press(4'd0);
    start_and_ack("e980", 12'h959);

    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("e1234_prev", pv(), 12'h234);
    chk("e1234_n", 12'(n_digitos), 12'h3);
    D = 4'd12;
    loadn = 1'b0;
    repeat (3) tick();
    chk("bad_erro_hi", 12'(erro), 12'h1);
    tick();
    chk("bad_erro_lo", 12'(erro), 12'h0);
    chk("bad_prev", pv(), 12'h234);
    chk("bad_n", 12'(n_digitos), 12'h3);
    loadn = 1'b1;
    repeat (3) tick();

    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_prev", pv(), 12'h000);
    chk("cancel_n", 12'(n_digitos), 12'h0);

    D = 4'd5;
    loadn = 1'b0;
    repeat (20) tick();
    loadn = 1'b1;
    repeat (3) tick();
    chk("hold_prev", pv(), 12'h005);
    chk("hold_n", 12'(n_digitos), 12'h1);

    enablen = 1'b1;
    press(4'd7);
    enablen = 1'b0;
    chk("inhibit_prev", pv(), 12'h005);
    chk("inhibit_n", 12'(n_digitos), 12'h1);

    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    press(4'd4);
    repeat (996) tick();
    chk("tmo_before", pv(), 12'h004);
    tick();
    chk("tmo_after", pv(), 12'h000);
    chk("tmo_n", 12'(n_digitos), 12'h0);

    press(4'd2);
    start_req = 1'b1;
    cancel    = 1'b1;
    tick();
    start_req = 1'b0;
    cancel    = 1'b0;
    chk("sc_prev", pv(), 12'h000);
    repeat (2) tick();
    chk("sc_req", 12'(load_req), 12'h0);

    press(4'd1);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    chk("mid_req", 12'(load_req), 12'h1);
    #2;
    clrn = 1'b0;
    #1;
    chk("async_req", 12'(load_req), 12'h0);
    tick();
    clrn = 1'b1;
    tick();
    chk("post_prev", pv(), 12'h000);
    chk("post_tmp", tv(), 12'h000);
    chk("post_n", 12'(n_digitos), 12'h0);
    chk("post_req", 12'(load_req), 12'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
